// File: rtl/temp_datapath_if.sv
// Sample/flag bus between the temperature compare stage and its neighbours.
// The master side drives the strobe and temperatures; the slave side returns the filtered flags.
interface temp_datapath_if #(
   parameter int W = 7
);
   logic         sample_en;
   logic [W-1:0] datapath_in1;
   logic [W-1:0] datapath_in2;
   logic [W-1:0] datapath_in3;
   logic [3:0]   datapath_out;
   logic         dout_valid;

   modport master (
      output sample_en, datapath_in1, datapath_in2, datapath_in3,
      input  datapath_out, dout_valid
   );

   modport slave (
      input  sample_en, datapath_in1, datapath_in2, datapath_in3,
      output datapath_out, dout_valid
   );
endinterface

// File: rtl/temp_datapath.sv
// Temperature compare stage: capture, threshold compare, per-flag persistence filter.
// Produces the controller's 4-bit status vector and a primed/valid indication.
module temp_datapath #(
   parameter int W        = 7,
   parameter int FILT_LEN = 4
) (
   input logic            clk,
   input logic            reset,
   temp_datapath_if.slave bus
);

   typedef enum logic [1:0] {
      PRIME = 2'b01,
      RUN   = 2'b10
   } state_e;

   localparam logic [3:0] CNT_MAX   = 4'(FILT_LEN - 1);
   localparam logic [3:0] PRIME_MAX = 4'(FILT_LEN);

   state_e       state_q, state_d;
   logic [W-1:0] troom_q, troom_d;
   logic [W-1:0] tref_q, tref_d;
   logic [W-1:0] dt_q, dt_d;
   logic         haveCap_q, haveCap_d;
   logic         capVld_q, capVld_d;
   logic         rawVld_q, rawVld_d;
   logic [3:0]   raw_q, raw_d;
   logic [3:0]   out_q, out_d;
   logic [3:0]   cnt_q [4];
   logic [3:0]   cnt_d [4];
   logic [3:0]   prime_q, prime_d;

   logic [W:0]   troomX, trefX, dtX;
   logic [3:0]   rawNext;
   logic         setChange;
   logic         stateBad;

   // One extra bit keeps troom+dt and tref+dt from wrapping at full scale.
   assign troomX  = {1'b0, troom_q};
   assign trefX   = {1'b0, tref_q};
   assign dtX     = {1'b0, dt_q};
   assign rawNext = {troomX <= trefX,
                     troomX >= trefX,
                     troomX > (trefX + dtX),
                     (troomX + dtX) < trefX};

   assign setChange = bus.sample_en && haveCap_q &&
                      ((bus.datapath_in2 != tref_q) || (bus.datapath_in3 != dt_q));
   assign stateBad  = (state_q != PRIME) && (state_q != RUN);

   assign bus.datapath_out = out_q;
   assign bus.dout_valid   = (state_q == RUN);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      troom_d   = troom_q;
      tref_d    = tref_q;
      dt_d      = dt_q;
      haveCap_d = haveCap_q;
      raw_d     = raw_q;
      out_d     = out_q;
      cnt_d     = cnt_q;
      prime_d   = prime_q;
      capVld_d  = bus.sample_en;
      rawVld_d  = capVld_q;

      if (bus.sample_en) begin
         troom_d   = bus.datapath_in1;
         tref_d    = bus.datapath_in2;
         dt_d      = bus.datapath_in3;
         haveCap_d = 1'b1;
      end

      if (capVld_q) begin
         raw_d = rawNext;
      end

      // A new setpoint restarts priming; the flags keep their last filtered value meanwhile.
      if (stateBad || setChange) begin
         for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
         end
         prime_d = '0;
         state_d = PRIME;
      end else if (rawVld_q) begin
         for (int i = 0; i < 4; i++) begin
            if (raw_q[i] == out_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               out_d[i] = raw_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
         if (prime_q != PRIME_MAX) begin
            prime_d = prime_q + 4'd1;
         end
         if (prime_d == PRIME_MAX) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         troom_q   <= '0;
         tref_q    <= '0;
         dt_q      <= '0;
         haveCap_q <= 1'b0;
         capVld_q  <= 1'b0;
         rawVld_q  <= 1'b0;
         raw_q     <= '0;
         out_q     <= '0;
         prime_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         troom_q   <= troom_d;
         tref_q    <= tref_d;
         dt_q      <= dt_d;
         haveCap_q <= haveCap_d;
         capVld_q  <= capVld_d;
         rawVld_q  <= rawVld_d;
         raw_q     <= raw_d;
         out_q     <= out_d;
         prime_q   <= prime_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_temp_datapath.sv
// Bench for temp_datapath: directed vector table, corner-case sequences and a randomized run
// compared against a sample-history reference model.
module tb_temp_datapath;

   localparam int W        = 7;
   localparam int FILT_LEN = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   temp_datapath_if #(.W(W)) busIf ();

   temp_datapath #(.W(W), .FILT_LEN(FILT_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] raw;
      int         due;
   } pend_t;

   typedef struct {
      logic       rst;
      logic       en;
      int         t;
      int         r;
      int         d;
      logic [3:0] expOut;
      logic       expVld;
   } vec_t;

   // Reference model: pending samples, applied-sample history, per-flag start of current run.
   pend_t      pendQ[$];
   logic [3:0] histQ[$];
   int         sinceIdx[4];
   logic [3:0] mOut = 4'b0000;
   int         mPrime = 0;
   logic       mVld = 1'b0;
   bit         mHaveCap = 1'b0;
   int         mLastTref = 0;
   int         mLastDt = 0;
   int         edgeNum = 0;

   function automatic logic [3:0] refFlags(int t, int r, int d);
      logic [3:0] f;
      f[0] = ((t + d) < r);
      f[1] = (t > (r + d));
      f[2] = (t >= r);
      f[3] = (t <= r);
      return f;
   endfunction

   task automatic clearHistory();
      histQ.delete();
      for (int i = 0; i < 4; i++) sinceIdx[i] = 0;
   endtask

   // A flag follows the raw value once the last FILT_LEN applied samples since its last change all disagree.
   task automatic modelApply(logic [3:0] raw);
      int  n;
      bit  allDiff;
      histQ.push_back(raw);
      if (mPrime < FILT_LEN) mPrime++;
      for (int i = 0; i < 4; i++) begin
         n = histQ.size() - sinceIdx[i];
         if (n >= FILT_LEN) begin
            allDiff = 1'b1;
            for (int k = histQ.size() - FILT_LEN; k < histQ.size(); k++) begin
               if (histQ[k][i] == mOut[i]) allDiff = 1'b0;
            end
            if (allDiff) begin
               mOut[i]     = raw[i];
               sinceIdx[i] = histQ.size();
            end
         end
      end
   endtask

   task automatic modelEdge(logic rst, logic en, int t, int r, int d);
      bit    change;
      pend_t s;
      edgeNum++;
      if (!rst) begin
         mOut     = 4'b0000;
         mPrime   = 0;
         mHaveCap = 1'b0;
         pendQ.delete();
         clearHistory();
      end else begin
         change = en && mHaveCap && ((r != mLastTref) || (d != mLastDt));
         if (pendQ.size() > 0 && pendQ[0].due == edgeNum) begin
            s = pendQ.pop_front();
            if (!change) modelApply(s.raw);
         end
         if (change) begin
            clearHistory();
            mPrime = 0;
         end
         if (en) begin
            pendQ.push_back('{refFlags(t, r, d), edgeNum + 2});
            mHaveCap  = 1'b1;
            mLastTref = r;
            mLastDt   = d;
         end
      end
      mVld = (mPrime >= FILT_LEN);
   endtask

   task automatic checkValue(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic checkOutput(string name, logic [3:0] expOut, logic expVld);
      checks++;
      if (busIf.datapath_out !== expOut) begin
         errors++;
         $display("[TB] FAIL %s.out got %b expected %b", name, busIf.datapath_out, expOut);
      end
      checks++;
      if (busIf.dout_valid !== expVld) begin
         errors++;
         $display("[TB] FAIL %s.valid got %b expected %b", name, busIf.dout_valid, expVld);
      end
   endtask

   // Drive one cycle at the falling edge, clock it, then compare just after the rising edge.
   task automatic applyStimulus(logic rst, logic en, int t, int r, int d, string name);
      reset              = rst;
      busIf.sample_en    = en;
      busIf.datapath_in1 = 7'(t);
      busIf.datapath_in2 = 7'(r);
      busIf.datapath_in3 = 7'(d);
      @(posedge clk);
      modelEdge(rst, en, t, r, d);
      #1;
      checkOutput({name, ".model"}, mOut, mVld);
      @(negedge clk);
   endtask

   vec_t vecs[9];

   initial begin
      int tr, rr, dr;

      reset              = 1'b0;
      busIf.sample_en    = 1'b0;
      busIf.datapath_in1 = '0;
      busIf.datapath_in2 = '0;
      busIf.datapath_in3 = '0;
      for (int i = 0; i < 4; i++) sinceIdx[i] = 0;

      // Reset with strobe held, then a steady cold room: heat_req and cool_done flip on the 4th filtered sample.
      vecs[0] = '{1'b0, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 15, 25, 3, 4'b0000, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 15, 25, 3, 4'b1001, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 15, 25, 3, 4'b1001, 1'b1};

      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].t, vecs[i].r, vecs[i].d, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d.table", i), vecs[i].expOut, vecs[i].expVld);
      end

      // Alternating raw cool_req never builds a run long enough to assert.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 28 : 29, 25, 3, "altCool");
         checkValue("altCool.coolReq", int'(busIf.datapath_out[1]), 0);
      end
      checkOutput("altCool.final", 4'b0100, 1'b1);

      // Equal temperatures set both done flags; full-scale values must not wrap.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 25, 25, 3, "equal");
      checkOutput("equal.final", 4'b1100, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 127, 127, 127, "fullScale");
      checkOutput("fullScale.final", 4'b1100, 1'b1);

      // Band change while running: valid drops at once, flags hold, valid returns after 4 samples.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 15, 25, 3, "preChange");
      checkOutput("preChange.final", 4'b1001, 1'b1);
      applyStimulus(1'b1, 1'b1, 15, 25, 5, "dtChange");
      checkOutput("dtChange.edge", 4'b1001, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 1'b1, 15, 25, 5, "reprime");
         checkOutput($sformatf("reprime%0d", k), 4'b1001, (k == 4));
      end

      // Reset lands while a sample is in flight; that sample must never reach the flags.
      applyStimulus(1'b1, 1'b1, 100, 25, 5, "inflight");
      applyStimulus(1'b0, 1'b0, 100, 25, 5, "midReset");
      checkOutput("midReset.edge", 4'b0000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 100, 25, 5, "postReset");
         checkOutput($sformatf("postReset%0d", k), 4'b0000, 1'b0);
      end

      // Randomized traffic around a slowly changing setpoint.
      rr = 40;
      dr = 4;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rr = $urandom_range(0, 127);
            dr = $urandom_range(0, 127);
         end
         if ($urandom_range(0, 1) == 0) tr = $urandom_range(0, 127);
         else begin
            tr = rr + int'($urandom_range(0, 20)) - 10;
            if (tr < 0) tr = 0;
            if (tr > 127) tr = 127;
         end
         applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, tr, rr, dr, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
